// File: rtl/lm32_inst_encoder.sv
// LM32 instruction assembler: structured request in, 32-bit instruction word out,
// through a two-stage valid/ready pipeline with range-error flag and handshake counters.
module lm32_inst_encoder #(
    parameter int CNT_W     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_opcode,
    input  logic [4:0]           req_ra,
    input  logic [4:0]           req_rb,
    input  logic [4:0]           req_rd,
    input  logic [31:0]          req_imm,
    input  logic [29:0]          req_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst_word,
    output logic                 inst_err,
    output logic [CNT_W-1:0]     enc_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_SHIFT,
        FMT_STORE,
        FMT_RI,
        FMT_BRANCH,
        FMT_JUMP,
        FMT_RR,
        FMT_UNDEF
    } fmt_e;

    function automatic fmt_e classify(input logic [5:0] op);
        fmt_e f;
        case (op)
            6'h00, 6'h05, 6'h0f:                      f = FMT_SHIFT;
            6'h03, 6'h0c, 6'h16:                      f = FMT_STORE;
            6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h17: f = FMT_BRANCH;
            6'h38, 6'h3e:                             f = FMT_JUMP;
            6'h27, 6'h2a, 6'h33:                      f = FMT_UNDEF;
            default:                                  f = op[5] ? FMT_RR : FMT_RI;
        endcase
        return f;
    endfunction

    logic        s1_valid_q;
    fmt_e        s1_fmt_q;
    logic [5:0]  s1_op_q;
    logic [4:0]  s1_ra_q, s1_rb_q, s1_rd_q;
    logic [31:0] s1_imm_q;
    logic [29:0] s1_off_q;

    logic        s2_valid_q;
    logic [31:0] s2_word_q;
    logic        s2_err_q;

    logic [CNT_W-1:0]     enc_count_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    fmt_e        fmt_d;
    logic [29:0] off_d;
    logic [31:0] word_d;
    logic        err_d;
    logic        s2_free;
    logic        out_fire;

    assign inst_valid = s2_valid_q;
    assign inst_word  = s2_word_q;
    assign inst_err   = s2_err_q;
    assign enc_count  = enc_count_q;
    assign err_count  = err_count_q;

    // S2 can take a new word when empty or draining this cycle; S1 follows the same rule.
    assign out_fire  = s2_valid_q && inst_ready;
    assign s2_free   = !s2_valid_q || inst_ready;
    assign req_ready = !s1_valid_q || s2_free;

    // Branch displacement is in words, relative to the instruction's own word PC.
    always_comb begin
        fmt_d = classify(req_opcode);
        off_d = req_imm[31:2] - req_pc;
    end

    always_comb begin
        word_d = {s1_op_q, s1_ra_q, 21'b0};
        err_d  = 1'b0;
        case (s1_fmt_q)
            FMT_SHIFT: begin
                word_d[20:0] = {s1_rd_q, 11'b0, s1_imm_q[4:0]};
                err_d        = |s1_imm_q[31:5];
            end
            FMT_STORE: begin
                word_d[20:0] = {s1_rb_q, s1_imm_q[15:0]};
            end
            FMT_RI: begin
                word_d[20:0] = {s1_rd_q, s1_imm_q[15:0]};
                err_d        = !((s1_imm_q[31:16] == 16'h0000) || (s1_imm_q[31:16] == 16'hFFFF));
            end
            FMT_BRANCH: begin
                word_d[20:0] = {s1_rb_q, s1_off_q[15:0]};
                err_d        = (|s1_imm_q[1:0]) || !((&s1_off_q[29:15]) || !(|s1_off_q[29:15]));
            end
            FMT_JUMP: begin
                word_d[25:0] = s1_off_q[25:0];
                err_d        = (|s1_imm_q[1:0]) || !((&s1_off_q[29:25]) || !(|s1_off_q[29:25]));
            end
            FMT_RR: begin
                word_d[20:0] = {s1_rb_q, s1_rd_q, 11'b0};
            end
            FMT_UNDEF: begin
                word_d[20:0] = {s1_rb_q, s1_rd_q, 11'b0};
                err_d        = 1'b1;
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= FMT_RR;
            s1_op_q     <= '0;
            s1_ra_q     <= '0;
            s1_rb_q     <= '0;
            s1_rd_q     <= '0;
            s1_imm_q    <= '0;
            s1_off_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_word_q   <= '0;
            s2_err_q    <= 1'b0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_word_q <= word_d;
                    s2_err_q  <= err_d;
                end
            end
            if (req_ready) begin
                s1_valid_q <= req_valid;
                if (req_valid) begin
                    s1_fmt_q <= fmt_d;
                    s1_op_q  <= req_opcode;
                    s1_ra_q  <= req_ra;
                    s1_rb_q  <= req_rb;
                    s1_rd_q  <= req_rd;
                    s1_imm_q <= req_imm;
                    s1_off_q <= off_d;
                end
            end
            if (out_fire) begin
                enc_count_q <= enc_count_q + CNT_W'(1);
                if (s2_err_q && !(&err_count_q)) begin
                    err_count_q <= err_count_q + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lm32_inst_encoder.sv
// Self-checking bench for lm32_inst_encoder: directed encodings from known words,
// randomized streams scored against a behavioural assembler model.
module tb_lm32_inst_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready, req_ready4;
    logic [5:0]  req_opcode;
    logic [4:0]  req_ra, req_rb, req_rd;
    logic [31:0] req_imm;
    logic [29:0] req_pc;
    logic        inst_valid, inst_valid4;
    logic        inst_ready;
    logic [31:0] inst_word, inst_word4;
    logic        inst_err, inst_err4;
    logic [15:0] enc_count;
    logic [7:0]  err_count;
    logic [3:0]  enc_count4;
    logic [1:0]  err_count4;

    int errors = 0;
    int checks = 0;
    int exp_enc = 0;
    int exp_err = 0;

    always #5 clk_i = ~clk_i;

    lm32_inst_encoder #(.CNT_W(16), .ERR_CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .req_imm(req_imm), .req_pc(req_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_err(inst_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    // Narrow-counter copy driven in lockstep to exercise wrap and saturation.
    lm32_inst_encoder #(.CNT_W(4), .ERR_CNT_W(2)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .req_imm(req_imm), .req_pc(req_pc),
        .inst_valid(inst_valid4), .inst_ready(inst_ready),
        .inst_word(inst_word4), .inst_err(inst_err4),
        .enc_count(enc_count4), .err_count(err_count4)
    );

    function automatic void model(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                                  input logic [4:0] rd, input logic [31:0] imm, input logic [29:0] pc,
                                  output logic [31:0] w, output logic e);
        longint d, off30, soff;
        longint unsigned uimm;
        uimm  = {32'b0, imm};
        d     = longint'(uimm / 4) - longint'({34'b0, pc});
        off30 = d & 64'h3FFF_FFFF;
        soff  = (off30 >= (64'd1 << 29)) ? off30 - (64'sd1 <<< 30) : off30;
        w = (32'(op) << 26) | (32'(ra) << 21);
        e = 1'b0;
        if (op inside {6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h17}) begin
            w = w | (32'(rb) << 16) | 32'(off30 % 65536);
            e = (uimm % 4 != 0) || (soff < -32768) || (soff > 32767);
        end else if (op inside {6'h38, 6'h3e}) begin
            w = (32'(op) << 26) | 32'(off30 % (64'd1 << 26));
            e = (uimm % 4 != 0) || (soff < -(64'sd1 <<< 25)) || (soff >= (64'sd1 <<< 25));
        end else if (op inside {6'h00, 6'h05, 6'h0f}) begin
            w = w | (32'(rd) << 16) | 32'(uimm % 32);
            e = uimm > 31;
        end else if (op inside {6'h03, 6'h0c, 6'h16}) begin
            w = w | (32'(rb) << 16) | 32'(uimm % 65536);
        end else if (op < 6'd32) begin
            w = w | (32'(rd) << 16) | 32'(uimm % 65536);
            e = !((uimm < 64'h1_0000) || (uimm >= 64'hFFFF_0000));
        end else begin
            w = w | (32'(rb) << 16) | (32'(rd) << 11);
            e = op inside {6'h27, 6'h2a, 6'h33};
        end
    endfunction

    task automatic gen_req();
        logic [31:0] r;
        logic [29:0] t;
        req_opcode = 6'($urandom_range(0, 63));
        req_ra     = 5'($urandom);
        req_rb     = 5'($urandom);
        req_rd     = 5'($urandom);
        req_pc     = 30'($urandom);
        r          = $urandom;
        case ($urandom_range(0, 3))
            0: req_imm = r;
            1: req_imm = r[15] ? {16'hFFFF, r[15:0]} : {16'h0000, r[15:0]};
            2: req_imm = 32'($urandom_range(0, 40));
            default: begin
                t       = req_pc + 30'($urandom_range(0, 70000)) - 30'd35000;
                req_imm = {t, 2'b00};
            end
        endcase
    endtask

    task automatic encode(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [29:0] pc,
                          output logic [31:0] w, output logic e, output int lat);
        int k;
        logic [31:0] mw;
        logic me;
        @(negedge clk_i);
        inst_ready = 1'b1;
        req_opcode = op; req_ra = ra; req_rb = rb; req_rd = rd; req_imm = imm; req_pc = pc;
        req_valid  = 1'b1;
        #1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk_i); #1; k++;
        end
        @(negedge clk_i);
        req_valid = 1'b0;
        #1;
        lat = 1;
        while (inst_valid !== 1'b1 && lat < 20) begin
            @(negedge clk_i); #1; lat++;
        end
        w = inst_word;
        e = inst_err;
        if (lat >= 20) begin
            errors++; checks++;
            $display("FAIL encode_timeout op=%02h: no inst_valid within 20 cycles", op);
        end
        model(op, ra, rb, rd, imm, pc, mw, me);
        exp_enc++;
        if (me) exp_err++;
        @(negedge clk_i); #1;
    endtask

    task automatic test_reset();
        int stale;
        rst_i = 1'b1; req_valid = 1'b0; inst_ready = 1'b0;
        req_opcode = '0; req_ra = '0; req_rb = '0; req_rd = '0; req_imm = '0; req_pc = '0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_word !== 32'h0 || inst_err !== 1'b0 || req_ready !== 1'b1 ||
            enc_count !== 16'h0 || err_count !== 8'h0)
            begin errors++; $display("FAIL reset_values: valid=%b word=%h err=%b rdy=%b enc=%0d errc=%0d, need 0/0/0/1/0/0",
                                     inst_valid, inst_word, inst_err, req_ready, enc_count, err_count); end
        @(negedge clk_i); rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            req_opcode = 6'h2d; req_ra = 5'd1; req_rb = 5'd2; req_rd = 5'(i);
            req_valid  = 1'b1;
        end
        @(negedge clk_i); #1;
        checks++;
        if (req_ready !== 1'b0 || inst_valid !== 1'b1)
            begin errors++; $display("FAIL backpressure_fill: req_ready=%b inst_valid=%b, need 0 1", req_ready, inst_valid); end
        rst_i = 1'b1; req_valid = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_word !== 32'h0 || inst_err !== 1'b0 || req_ready !== 1'b1 ||
            enc_count !== 16'h0 || err_count !== 8'h0)
            begin errors++; $display("FAIL reset_midstream: valid=%b word=%h err=%b rdy=%b enc=%0d, need 0/0/0/1/0",
                                     inst_valid, inst_word, inst_err, req_ready, enc_count); end
        @(negedge clk_i); rst_i = 1'b0; inst_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); #1;
            if (inst_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0 || enc_count !== 16'h0)
            begin errors++; $display("FAIL reset_stale: stale_cycles=%0d enc=%0d, need 0 0", stale, enc_count); end
        exp_enc = 0; exp_err = 0;
    endtask

    task automatic test_ri();
        logic [31:0] w; logic e; int lat;
        encode(6'h0d, 5'd3, 5'd0, 5'd4, 32'hFFFF_FFF0, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'h3464FFF0 || e !== 1'b0)
            begin errors++; $display("FAIL addi_neg: word=%h err=%b, need 3464fff0 0", w, e); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL latency: %0d cycles, need 2", lat); end
        encode(6'h0d, 5'd3, 5'd0, 5'd4, 32'h0001_0000, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'h34640000 || e !== 1'b1)
            begin errors++; $display("FAIL addi_range: word=%h err=%b, need 34640000 1", w, e); end
        checks++;
        if (err_count !== 8'd1 || enc_count !== 16'd2)
            begin errors++; $display("FAIL addi_counts: err_count=%0d enc_count=%0d, need 1 2", err_count, enc_count); end
        encode(6'h16, 5'd5, 5'd6, 5'd0, 32'hABCD_8000, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'h58A68000 || e !== 1'b0)
            begin errors++; $display("FAIL store: word=%h err=%b, need 58a68000 0", w, e); end
    endtask

    task automatic test_branch();
        logic [31:0] w; logic e; int lat;
        encode(6'h11, 5'd1, 5'd2, 5'd0, 32'h0000_03F8, 30'h100, w, e, lat);
        checks++;
        if (w !== 32'h4422FFFE || e !== 1'b0)
            begin errors++; $display("FAIL be_back: word=%h err=%b, need 4422fffe 0", w, e); end
        encode(6'h11, 5'd1, 5'd2, 5'd0, 32'h0000_03FA, 30'h100, w, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL be_misaligned: err=%b, need 1", e); end
    endtask

    task automatic test_calli();
        logic [31:0] w; logic e; int lat;
        encode(6'h3e, 5'd0, 5'd0, 5'd0, 32'h0800_0000, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'hFA000000 || e !== 1'b1)
            begin errors++; $display("FAIL calli_range: word=%h err=%b, need fa000000 1", w, e); end
        encode(6'h3e, 5'd0, 5'd0, 5'd0, 32'h07FF_FFFC, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'hF9FFFFFF || e !== 1'b0)
            begin errors++; $display("FAIL calli_max: word=%h err=%b, need f9ffffff 0", w, e); end
    endtask

    task automatic test_rr_shift();
        logic [31:0] w; logic e; int lat;
        encode(6'h2d, 5'd1, 5'd2, 5'd3, 32'h0, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'hB4221800 || e !== 1'b0)
            begin errors++; $display("FAIL add_rr: word=%h err=%b, need b4221800 0", w, e); end
        encode(6'h0f, 5'd1, 5'd0, 5'd2, 32'd33, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'h3C220001 || e !== 1'b1)
            begin errors++; $display("FAIL sli_range: word=%h err=%b, need 3c220001 1", w, e); end
        encode(6'h27, 5'd1, 5'd2, 5'd3, 32'h0, 30'd0, w, e, lat);
        checks++;
        if (w !== 32'h9C221800 || e !== 1'b1)
            begin errors++; $display("FAIL undef_op: word=%h err=%b, need 9c221800 1", w, e); end
    endtask

    task automatic test_counters();
        int sat4;
        sat4 = (exp_err > 3) ? 3 : exp_err;
        checks++;
        if (enc_count !== 16'(exp_enc) || err_count !== 8'(exp_err))
            begin errors++; $display("FAIL counters: enc=%0d err=%0d, need %0d %0d", enc_count, err_count, exp_enc, exp_err); end
        checks++;
        if (enc_count4 !== 4'(exp_enc % 16) || err_count4 !== 2'(sat4))
            begin errors++; $display("FAIL narrow_counters: enc=%0d err=%0d, need %0d %0d", enc_count4, err_count4, exp_enc % 16, sat4); end
    endtask

    task automatic test_stream(input int n, input bit rnd);
        logic [31:0] q_w[$];
        logic        q_e[$];
        logic [31:0] ew, held_w;
        logic        ee, held_e;
        int  sent, got, cyc;
        bit  have, held_v;
        sent = 0; got = 0; cyc = 0; have = 0; held_v = 0; held_w = '0; held_e = 1'b0;
        while (got < n && cyc < n * 20 + 50) begin
            @(negedge clk_i); cyc++;
            inst_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!have && sent < n) begin gen_req(); have = 1; end
            req_valid = have;
            #1;
            if (held_v) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_word !== held_w || inst_err !== held_e)
                    begin errors++; $display("FAIL hold_stable: valid=%b word=%h err=%b, need 1 %h %b",
                                             inst_valid, inst_word, inst_err, held_w, held_e); end
            end
            if (!rnd && have) begin
                checks++;
                if (req_ready !== 1'b1 || req_ready4 !== 1'b1)
                    begin errors++; $display("FAIL full_rate: req_ready=%b at cycle %0d, need 1", req_ready, cyc); end
            end
            if (inst_valid === 1'b1 && inst_ready) begin
                checks++;
                if (q_w.size() == 0) begin
                    errors++; $display("FAIL stream_dup: word=%h emitted with nothing expected", inst_word);
                end else begin
                    ew = q_w.pop_front(); ee = q_e.pop_front();
                    if (inst_word !== ew || inst_err !== ee || inst_word4 !== ew || inst_err4 !== ee || inst_valid4 !== 1'b1)
                        begin errors++; $display("FAIL stream_word %0d: word=%h err=%b, need %h %b", got, inst_word, inst_err, ew, ee); end
                    if (ee) exp_err++;
                end
                got++; exp_enc++;
            end
            held_v = (inst_valid === 1'b1) && !inst_ready;
            held_w = inst_word; held_e = inst_err;
            if (have && req_ready === 1'b1) begin
                model(req_opcode, req_ra, req_rb, req_rd, req_imm, req_pc, ew, ee);
                q_w.push_back(ew); q_e.push_back(ee);
                have = 0; sent++;
            end
        end
        req_valid = 1'b0; inst_ready = 1'b1;
        checks++;
        if (got != n) begin errors++; $display("FAIL stream_timeout: received %0d words, need %0d", got, n); end
        if (!rnd) begin
            checks++;
            if (cyc != n + 2) begin errors++; $display("FAIL full_rate_cycles: %0d cycles, need %0d", cyc, n + 2); end
        end
        @(negedge clk_i); #1;
        checks++;
        if (inst_valid !== 1'b0 || q_w.size() != 0)
            begin errors++; $display("FAIL stream_drain: inst_valid=%b leftover=%0d, need 0 0", inst_valid, q_w.size()); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0;
        exp_enc = 0; exp_err = 0;
        test_stream(64, 1'b1);
        checks++;
        if (enc_count !== 16'd64 || enc_count4 !== 4'd0)
            begin errors++; $display("FAIL b2b_count: enc=%0d enc4=%0d, need 64 0", enc_count, enc_count4); end
        test_counters();
    endtask

    task automatic test_full_rate();
        test_stream(24, 1'b0);
        test_counters();
    endtask

    initial begin
        test_reset();
        test_ri();
        test_branch();
        test_calli();
        test_rr_shift();
        test_counters();
        test_back_to_back();
        test_full_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
